clock_enable_scheduler: RTL and testbench

//   Sequences the system clock domain: derives the GBA CPU clock-enable (16.78 MHz nominal) from master_clock with a

---
 rtl/clock_enable_scheduler.sv | 129 ++++++++++++
 tb/tb_clock_enable_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_scheduler.sv
// Clock-enable scheduler: fractional phase accumulator producing the CPU tick, timer
// prescaler enables and RUN/HALT/STOP gating, all on master_clock with no derived clocks.
module clock_enable_scheduler #(
    parameter int unsigned MASTER_HZ = 100_000_000,
    parameter int unsigned TARGET_HZ = 16_777_216,
    parameter int unsigned ACC_W     = 32
) (
    input  logic        master_clock,
    input  logic        reset,
    input  logic        halt_req,
    input  logic        stop_req,
    input  logic        wake,
    output logic        cpu_ce,
    output logic [3:0]  timer_ce,
    output logic [1:0]  power_state,
    output logic [31:0] tick_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam longint unsigned MAX_SUM = 64'(MASTER_HZ) + 64'(TARGET_HZ) - 64'd1;
    localparam logic [ACC_W-1:0] MASTER_C = ACC_W'(MASTER_HZ);
    localparam logic [ACC_W-1:0] TARGET_C = ACC_W'(TARGET_HZ);

    if ((TARGET_HZ == 32'd0) || (TARGET_HZ >= MASTER_HZ)) begin : g_bad_rate
        $error("clock_enable_scheduler: TARGET_HZ must satisfy 0 < TARGET_HZ < MASTER_HZ");
    end
    if ((ACC_W < 32'd64) && (MAX_SUM >= (64'd1 << ACC_W))) begin : g_bad_width
        $error("clock_enable_scheduler: ACC_W too narrow for MASTER_HZ+TARGET_HZ-1");
    end

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] sum_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             tick_s;
    logic [9:0]       presc_r;
    state_t           state_r;
    state_t           state_next_s;
    logic [3:0]       timer_ce_next_s;
    logic             cpu_ce_r;
    logic [3:0]       timer_ce_r;
    logic [31:0]      tick_count_r;

    // Phase accumulator: the tick is the carry out of the modulo-MASTER_HZ sum.
    always_comb begin
        sum_s      = acc_r + TARGET_C;
        tick_s     = 1'b0;
        acc_next_s = sum_s;
        if (sum_s >= MASTER_C) begin
            tick_s     = 1'b1;
            acc_next_s = sum_s - MASTER_C;
        end else begin
            tick_s     = 1'b0;
            acc_next_s = sum_s;
        end
    end

    // Power-state transitions; a pending wake holds the CPU in RUN over any request.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (wake) begin
                    state_next_s = ST_RUN;
                end else if (stop_req) begin
                    state_next_s = ST_STOP;
                end else if (halt_req) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT, ST_STOP: begin
                if (wake) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Prescaler enables compare the pre-increment count and are silenced in STOP.
    always_comb begin
        timer_ce_next_s = 4'b0000;
        if (state_r != ST_STOP) begin
            timer_ce_next_s = {tick_s & (presc_r == 10'd1023),
                               tick_s & (presc_r[7:0] == 8'd255),
                               tick_s & (presc_r[5:0] == 6'd63),
                               tick_s};
        end else begin
            timer_ce_next_s = 4'b0000;
        end
    end

    // State and registered outputs; tick_count and acc keep running in every power state.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            acc_r        <= '0;
            presc_r      <= 10'd0;
            state_r      <= ST_RUN;
            tick_count_r <= 32'd0;
            cpu_ce_r     <= 1'b0;
            timer_ce_r   <= 4'b0000;
        end else begin
            acc_r      <= acc_next_s;
            state_r    <= state_next_s;
            cpu_ce_r   <= tick_s & (state_r == ST_RUN);
            timer_ce_r <= timer_ce_next_s;
            if (tick_s) begin
                tick_count_r <= tick_count_r + 32'd1;
            end
            if (tick_s && (state_r != ST_STOP)) begin
                presc_r <= presc_r + 10'd1;
            end
        end
    end

    assign cpu_ce      = cpu_ce_r;
    assign timer_ce    = timer_ce_r;
    assign power_state = state_r;
    assign tick_count  = tick_count_r;

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Bench for clock_enable_scheduler: a cycle model pushes expected outputs into a queue as
// stimulus is driven; scenario tasks pop and compare after each edge, plus fixed-value checks.
module tb_clock_enable_scheduler;

    typedef struct packed {
        logic        cpu_ce;
        logic [3:0]  timer_ce;
        logic [1:0]  ps;
        logic [31:0] tc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt_req = 1'b0;
    logic        stop_req = 1'b0;
    logic        wake = 1'b0;
    logic        cpu_ce, cpu_ce2;
    logic [3:0]  timer_ce, timer_ce2;
    logic [1:0]  power_state, power_state2;
    logic [31:0] tick_count, tick_count2;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];

    // reference model state
    int unsigned m_acc = 0;
    int unsigned m_presc = 0;
    int unsigned m_st = 0;
    logic [31:0] m_tc = 32'd0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    clock_enable_scheduler #(.MASTER_HZ(4), .TARGET_HZ(1), .ACC_W(32)) dut (
        .master_clock(clk), .reset(reset), .halt_req(halt_req), .stop_req(stop_req),
        .wake(wake), .cpu_ce(cpu_ce), .timer_ce(timer_ce), .power_state(power_state),
        .tick_count(tick_count)
    );

    clock_enable_scheduler #(.MASTER_HZ(5), .TARGET_HZ(2), .ACC_W(32)) dut2 (
        .master_clock(clk), .reset(reset), .halt_req(1'b0), .stop_req(1'b0),
        .wake(1'b0), .cpu_ce(cpu_ce2), .timer_ce(timer_ce2), .power_state(power_state2),
        .tick_count(tick_count2)
    );

    task automatic advance(input logic h, input logic s, input logic w, input logic r);
        exp_t e;
        logic tick;
        halt_req = h;
        stop_req = s;
        wake     = w;
        reset    = r;
        e = '0;
        if (r) begin
            m_acc = 0; m_presc = 0; m_st = 0; m_tc = 32'd0; cyc = 0;
        end else begin
            cyc++;
            tick = ((m_acc + 1) >= 4);
            m_acc = tick ? (m_acc + 1 - 4) : (m_acc + 1);
            e.cpu_ce = tick && (m_st == 0);
            if (m_st != 2) begin
                e.timer_ce[0] = tick;
                e.timer_ce[1] = tick && ((m_presc % 64) == 63);
                e.timer_ce[2] = tick && ((m_presc % 256) == 255);
                e.timer_ce[3] = tick && (m_presc == 1023);
                if (tick) m_presc = (m_presc + 1) % 1024;
            end
            if (tick) m_tc = m_tc + 32'd1;
            case (m_st)
                0: m_st = w ? 0 : (s ? 2 : (h ? 1 : 0));
                default: m_st = w ? 0 : m_st;
            endcase
            e.tc = m_tc;
        end
        e.ps = m_st[1:0];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        advance(1'b0, 1'b0, 1'b0, 1'b1);
        advance(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            e = sb_q.pop_front(); n_cmp++;
            if ({cpu_ce, timer_ce, power_state, tick_count} !== e) begin
                n_err++; $display("FAIL sb_reset: got %h want %h", {cpu_ce, timer_ce, power_state, tick_count}, e);
            end
        end
        for (int i = 1; i <= 12; i++) begin
            advance(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); n_cmp++;
            if ({cpu_ce, timer_ce, power_state, tick_count} !== e) begin
                n_err++; $display("FAIL sb_release edge %0d: got %h want %h", i, {cpu_ce, timer_ce, power_state, tick_count}, e);
            end
            n_cmp++;
            if (cpu_ce !== ((i % 4) == 0)) begin
                n_err++; $display("FAIL release_cpu_ce edge %0d: got %b want %b", i, cpu_ce, ((i % 4) == 0));
            end
        end
        n_cmp++;
        if (tick_count !== 32'd3) begin
            n_err++; $display("FAIL release_tick_count: got %0d want 3", tick_count);
        end
    endtask

    task automatic test_fractional();
        exp_t e;
        logic prev = 1'b0;
        advance(1'b0, 1'b0, 1'b0, 1'b1);
        e = sb_q.pop_front();
        for (int c = 1; c <= 1000; c++) begin
            advance(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); n_cmp++;
            if ({cpu_ce, timer_ce, power_state, tick_count} !== e) begin
                n_err++; $display("FAIL sb_frac cyc %0d: got %h want %h", c, {cpu_ce, timer_ce, power_state, tick_count}, e);
            end
            if (c <= 10) begin
                n_cmp++;
                if (cpu_ce2 !== (c == 3 || c == 5 || c == 8 || c == 10)) begin
                    n_err++; $display("FAIL frac_tick cyc %0d: got %b want %b", c, cpu_ce2, (c == 3 || c == 5 || c == 8 || c == 10));
                end
            end
            if (prev && cpu_ce2) begin
                n_err++; $display("FAIL frac_adjacent cyc %0d: got two ticks want none adjacent", c);
            end
            prev = cpu_ce2;
        end
        n_cmp++;
        if (tick_count2 !== 32'd400) begin
            n_err++; $display("FAIL frac_count: got %0d want 400", tick_count2);
        end
    endtask

    task automatic test_prescaler();
        exp_t e;
        int cnt[4];
        int first64 = -1;
        for (int b = 0; b < 4; b++) cnt[b] = 0;
        advance(1'b0, 1'b0, 1'b0, 1'b1);
        e = sb_q.pop_front();
        for (int c = 1; c <= 4096; c++) begin
            advance(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); n_cmp++;
            if ({cpu_ce, timer_ce, power_state, tick_count} !== e) begin
                n_err++; $display("FAIL sb_presc cyc %0d: got %h want %h", c, {cpu_ce, timer_ce, power_state, tick_count}, e);
            end
            for (int b = 0; b < 4; b++) if (timer_ce[b]) cnt[b]++;
            if (timer_ce[1] && first64 < 0) first64 = int'(tick_count);
        end
        n_cmp++;
        if (first64 != 64) begin
            n_err++; $display("FAIL presc_first64: got tick %0d want 64", first64);
        end
        n_cmp++;
        if (cnt[0] != 1024 || cnt[1] != 16 || cnt[2] != 4 || cnt[3] != 1) begin
            n_err++; $display("FAIL presc_counts: got %0d/%0d/%0d/%0d want 1024/16/4/1", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
    endtask

    task automatic test_halt();
        exp_t e;
        int t0 = 0;
        int found = 0;
        advance(1'b1, 1'b0, 1'b0, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (power_state !== 2'd1 || {cpu_ce, timer_ce, power_state, tick_count} !== e) begin
            n_err++; $display("FAIL halt_enter: got %h want %h", {cpu_ce, timer_ce, power_state, tick_count}, e);
        end
        for (int c = 0; c < 12; c++) begin
            advance(1'b0, 1'b1, 1'b0, 1'b0);
            e = sb_q.pop_front(); n_cmp++;
            if ({cpu_ce, timer_ce, power_state, tick_count} !== e || cpu_ce !== 1'b0 || power_state !== 2'd1) begin
                n_err++; $display("FAIL sb_halt: got %h want %h", {cpu_ce, timer_ce, power_state, tick_count}, e);
            end
            if (timer_ce[0]) t0++;
        end
        n_cmp++;
        if (t0 != 3) begin
            n_err++; $display("FAIL halt_timer: got %0d pulses want 3", t0);
        end
        advance(1'b0, 1'b0, 1'b1, 1'b0);
        e = sb_q.pop_front();
        for (int c = 0; c < 8; c++) begin
            advance(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); n_cmp++;
            if ({cpu_ce, timer_ce, power_state, tick_count} !== e || power_state !== 2'd0) begin
                n_err++; $display("FAIL sb_halt_wake: got %h want %h", {cpu_ce, timer_ce, power_state, tick_count}, e);
            end
            if (cpu_ce) begin
                found++;
                n_cmp++;
                if ((cyc % 4) != 0) begin
                    n_err++; $display("FAIL halt_phase: got cpu_ce at cycle %0d want multiple of 4", cyc);
                end
            end
        end
        n_cmp++;
        if (found != 2) begin
            n_err++; $display("FAIL halt_resume: got %0d cpu_ce want 2", found);
        end
    endtask

    task automatic test_stop();
        exp_t e;
        int unsigned p;
        logic [31:0] tc0;
        int ticks = 0;
        int fired = 0;
        advance(1'b1, 1'b1, 1'b0, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (power_state !== 2'd2 || {cpu_ce, timer_ce, power_state, tick_count} !== e) begin
            n_err++; $display("FAIL stop_enter: got %h want %h", {cpu_ce, timer_ce, power_state, tick_count}, e);
        end
        p = m_presc;
        tc0 = tick_count;
        for (int c = 0; c < 12; c++) begin
            advance(1'b1, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); n_cmp++;
            if ({cpu_ce, timer_ce, power_state, tick_count} !== e || {cpu_ce, timer_ce} !== 5'd0) begin
                n_err++; $display("FAIL sb_stop: got %h want %h", {cpu_ce, timer_ce, power_state, tick_count}, e);
            end
        end
        n_cmp++;
        if (tick_count !== tc0 + 32'd3) begin
            n_err++; $display("FAIL stop_tick_count: got %0d want %0d", tick_count, tc0 + 32'd3);
        end
        advance(1'b0, 1'b0, 1'b1, 1'b0);
        e = sb_q.pop_front();
        for (int c = 0; c < 300 && fired == 0; c++) begin
            advance(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); n_cmp++;
            if ({cpu_ce, timer_ce, power_state, tick_count} !== e) begin
                n_err++; $display("FAIL sb_stop_wake: got %h want %h", {cpu_ce, timer_ce, power_state, tick_count}, e);
            end
            if (timer_ce[0]) ticks++;
            if (timer_ce[1]) fired = 1;
        end
        n_cmp++;
        if (fired == 0 || ticks != int'(64 - (p % 64))) begin
            n_err++; $display("FAIL stop_resume_presc: got fired=%0d after %0d ticks want %0d ticks", fired, ticks, 64 - (p % 64));
        end
    endtask

    task automatic test_wake_priority_and_reset();
        exp_t e;
        advance(1'b1, 1'b0, 1'b1, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (power_state !== 2'd0 || {cpu_ce, timer_ce, power_state, tick_count} !== e) begin
            n_err++; $display("FAIL wake_blocks_halt: got %h want %h", {cpu_ce, timer_ce, power_state, tick_count}, e);
        end
        advance(1'b0, 1'b1, 1'b1, 1'b0);
        e = sb_q.pop_front(); n_cmp++;
        if (power_state !== 2'd0 || {cpu_ce, timer_ce, power_state, tick_count} !== e) begin
            n_err++; $display("FAIL wake_blocks_stop: got %h want %h", {cpu_ce, timer_ce, power_state, tick_count}, e);
        end
        advance(1'b1, 1'b0, 1'b0, 1'b0);
        e = sb_q.pop_front();
        advance(1'b0, 1'b1, 1'b0, 1'b1);
        e = sb_q.pop_front(); n_cmp++;
        if ({cpu_ce, timer_ce, power_state, tick_count} !== 39'd0 || e !== 39'd0) begin
            n_err++; $display("FAIL reset_in_halt: got %h want 0", {cpu_ce, timer_ce, power_state, tick_count});
        end
        for (int i = 1; i <= 8; i++) begin
            advance(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); n_cmp++;
            if ({cpu_ce, timer_ce, power_state, tick_count} !== e || cpu_ce !== ((i % 4) == 0)) begin
                n_err++; $display("FAIL sb_after_reset edge %0d: got %h want %h", i, {cpu_ce, timer_ce, power_state, tick_count}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fractional();
        test_prescaler();
        test_halt();
        test_stop();
        test_wake_priority_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
